// File: rtl/channel_out.sv
// Purpose: one WS2812-style serial output channel; reads 24-bit pixels from colour RAM and emits the T0H/T0L/T1H/T1L waveform, then a latch low period.
// Latency: first high edge 3 cycles after start_i (READ, LOAD, then BIT_H); done_o pulses on the last latch cycle.
// Backpressure: none; start_i is ignored while busy_o is high (including the done_o cycle), and RAM data is taken exactly 1 cycle after the read strobe.
module channel_out #(
    parameter logic [15:0] RST_CYCLES = 16'd16000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic [7:0]  reg_t0h_time_i,
    input  logic [7:0]  reg_t0l_time_i,
    input  logic [7:0]  reg_t1h_time_i,
    input  logic [7:0]  reg_t1l_time_i,
    input  logic [7:0]  reg_chan_len_i,
    output logic        ram_rd_en_o,
    output logic [7:0]  ram_rd_addr_o,
    input  logic [31:0] ram_rd_data_i,
    output logic        bit_code_o,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LOAD,
        BIT_H,
        BIT_L,
        LATCH
    } state_t;

    state_t      state;
    logic [7:0]  t0h_q;
    logic [7:0]  t0l_q;
    logic [7:0]  t1h_q;
    logic [7:0]  t1l_q;
    logic [7:0]  len_q;
    logic [7:0]  addr;
    logic [23:0] shift;
    logic [4:0]  bit_cnt;
    logic [7:0]  dur;
    logic [15:0] lcnt;

    // The address register is the read address in every state; only the strobe marks a real read.
    assign ram_rd_addr_o = addr;

    // Frame sequencer: timing snapshot, pixel fetch, per-bit high/low phases and the latch period.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            t0h_q       <= 8'd0;
            t0l_q       <= 8'd0;
            t1h_q       <= 8'd0;
            t1l_q       <= 8'd0;
            len_q       <= 8'd0;
            addr        <= 8'd0;
            shift       <= 24'd0;
            bit_cnt     <= 5'd0;
            dur         <= 8'd0;
            lcnt        <= 16'd0;
            ram_rd_en_o <= 1'b0;
            bit_code_o  <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            ram_rd_en_o <= 1'b0;
            done_o      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        // Snapshot so register writes mid-frame only affect the next frame.
                        t0h_q       <= reg_t0h_time_i;
                        t0l_q       <= reg_t0l_time_i;
                        t1h_q       <= reg_t1h_time_i;
                        t1l_q       <= reg_t1l_time_i;
                        len_q       <= reg_chan_len_i;
                        addr        <= 8'd0;
                        busy_o      <= 1'b1;
                        ram_rd_en_o <= 1'b1;
                        state       <= READ;
                    end
                end
                READ: begin
                    state <= LOAD;
                end
                LOAD: begin
                    // Upper byte of the RAM word is unused; pixel is GRB in bits 23:0.
                    shift      <= ram_rd_data_i[23:0];
                    bit_cnt    <= 5'd23;
                    dur        <= ram_rd_data_i[23] ? t1h_q : t0h_q;
                    bit_code_o <= 1'b1;
                    state      <= BIT_H;
                end
                BIT_H: begin
                    if (dur == 8'd0) begin
                        bit_code_o <= 1'b0;
                        dur        <= shift[23] ? t1l_q : t0l_q;
                        state      <= BIT_L;
                    end else begin
                        dur <= dur - 8'd1;
                    end
                end
                BIT_L: begin
                    if (dur != 8'd0) begin
                        dur <= dur - 8'd1;
                    end else if (bit_cnt != 5'd0) begin
                        // Next bit is shift[22]; choose its high time before the shift lands.
                        shift      <= {shift[22:0], 1'b0};
                        bit_cnt    <= bit_cnt - 5'd1;
                        dur        <= shift[22] ? t1h_q : t0h_q;
                        bit_code_o <= 1'b1;
                        state      <= BIT_H;
                    end else if (addr == len_q) begin
                        lcnt   <= RST_CYCLES - 16'd1;
                        done_o <= (RST_CYCLES == 16'd1);
                        state  <= LATCH;
                    end else begin
                        // READ+LOAD stretch this pixel's last low phase by two cycles.
                        addr        <= addr + 8'd1;
                        ram_rd_en_o <= 1'b1;
                        state       <= READ;
                    end
                end
                LATCH: begin
                    if (lcnt == 16'd0) begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        lcnt   <= lcnt - 16'd1;
                        done_o <= (lcnt == 16'd1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_channel_out.sv
// Purpose: self-checking bench for channel_out against a run-length waveform model.
// Latency: frames are checked after busy_o falls; every wait is cycle-bounded.
// Backpressure: n/a; the bench models a RAM with 1-cycle read latency.
module tb_channel_out;

    localparam int RST = 2000;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        start_i = 1'b0;
    logic [7:0]  reg_t0h_time_i = 8'd0;
    logic [7:0]  reg_t0l_time_i = 8'd0;
    logic [7:0]  reg_t1h_time_i = 8'd0;
    logic [7:0]  reg_t1l_time_i = 8'd0;
    logic [7:0]  reg_chan_len_i = 8'd0;
    logic        ram_rd_en_o;
    logic [7:0]  ram_rd_addr_o;
    logic [31:0] ram_rd_data_i = 32'd0;
    logic        bit_code_o;
    logic        busy_o;
    logic        done_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [256];
    logic        q_bits [$];
    int          q_addr [$];
    int          exp_runs [$];
    int          act_runs [$];
    int          done_cnt = 0;
    int          done_idx = -1;

    channel_out #(.RST_CYCLES(16'(RST))) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .start_i        (start_i),
        .reg_t0h_time_i (reg_t0h_time_i),
        .reg_t0l_time_i (reg_t0l_time_i),
        .reg_t1h_time_i (reg_t1h_time_i),
        .reg_t1l_time_i (reg_t1l_time_i),
        .reg_chan_len_i (reg_chan_len_i),
        .ram_rd_en_o    (ram_rd_en_o),
        .ram_rd_addr_o  (ram_rd_addr_o),
        .ram_rd_data_i  (ram_rd_data_i),
        .bit_code_o     (bit_code_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    always #5 clk_i = ~clk_i;

    // RAM model: data valid one cycle after the strobe, garbage otherwise.
    always @(posedge clk_i) begin
        if (ram_rd_en_o) ram_rd_data_i <= mem[ram_rd_addr_o];
        else             ram_rd_data_i <= $urandom();
    end

    // Monitor: record the line level for every busy cycle, read addresses and done pulses.
    always @(negedge clk_i) begin
        if (busy_o) q_bits.push_back(bit_code_o);
        if (ram_rd_en_o) q_addr.push_back(int'(ram_rd_addr_o));
        if (done_o) begin
            done_cnt = done_cnt + 1;
            done_idx = q_bits.size() - 1;
        end
    end

    // Reference: alternating run lengths of the busy window, starting with a low run.
    function automatic void model_frame(input logic [7:0] a0h, a0l, a1h, a1l, ln);
        exp_runs.delete();
        exp_runs.push_back(2);
        for (int p = 0; p <= int'(ln); p++) begin
            for (int b = 23; b >= 0; b--) begin
                logic bv;
                int   hi;
                int   lo;
                bv = mem[p][b];
                hi = int'(bv ? a1h : a0h) + 1;
                lo = int'(bv ? a1l : a0l) + 1;
                if (b == 0) lo = lo + ((p == int'(ln)) ? RST : 2);
                exp_runs.push_back(hi);
                exp_runs.push_back(lo);
            end
        end
    endfunction

    function automatic void compress();
        logic lvl;
        int   n;
        act_runs.delete();
        lvl = 1'b0;
        n = 0;
        foreach (q_bits[i]) begin
            if (q_bits[i] == lvl) n++;
            else begin
                act_runs.push_back(n);
                lvl = q_bits[i];
                n = 1;
            end
        end
        act_runs.push_back(n);
    endfunction

    task automatic set_regs(input logic [7:0] a0h, a0l, a1h, a1l, ln);
        reg_t0h_time_i = a0h;
        reg_t0l_time_i = a0l;
        reg_t1h_time_i = a1h;
        reg_t1l_time_i = a1l;
        reg_chan_len_i = ln;
    endtask

    task automatic run_frame(output bit to);
        int n;
        q_bits.delete();
        q_addr.delete();
        done_cnt = 0;
        done_idx = -1;
        to = 1'b0;
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        n = 0;
        while (busy_o && n < 60000) begin
            @(negedge clk_i);
            n++;
        end
        if (busy_o) to = 1'b1;
        repeat (3) @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        repeat (3) @(negedge clk_i);
        checks++; if (bit_code_o !== 1'b0) begin errors++; $display("FAIL reset_bit_code got %b want 0", bit_code_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done_o); end
        checks++; if (ram_rd_en_o !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b want 0", ram_rd_en_o); end
        checks++; if (ram_rd_addr_o !== 8'd0) begin errors++; $display("FAIL reset_rd_addr got %0d want 0", ram_rd_addr_o); end
        rst_n_i = 1'b1;
        repeat (2) @(negedge clk_i);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy_o); end
    endtask

    task automatic test_timing();
        bit to;
        mem[0] = 32'h0080_0001;
        set_regs(8'h01, 8'h12, 8'h23, 8'h34, 8'h00);
        model_frame(8'h01, 8'h12, 8'h23, 8'h34, 8'h00);
        run_frame(to);
        compress();
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL timing_timeout busy still high"); end
        checks++; if (act_runs.size() !== exp_runs.size()) begin errors++; $display("FAIL timing_nruns got %0d want %0d", act_runs.size(), exp_runs.size()); end
        for (int i = 0; i < act_runs.size() && i < exp_runs.size(); i++) begin
            checks++;
            if (act_runs[i] !== exp_runs[i]) begin errors++; $display("FAIL timing_run[%0d] got %0d want %0d", i, act_runs[i], exp_runs[i]); break; end
        end
        checks++; if (q_addr.size() !== 1) begin errors++; $display("FAIL timing_nreads got %0d want 1", q_addr.size()); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL timing_done_count got %0d want 1", done_cnt); end
        checks++; if (done_idx !== q_bits.size() - 1) begin errors++; $display("FAIL timing_done_pos got %0d want %0d", done_idx, q_bits.size() - 1); end
        checks++; if (busy_o !== 1'b0 || bit_code_o !== 1'b0) begin errors++; $display("FAIL timing_after busy %b line %b want 0 0", busy_o, bit_code_o); end
    endtask

    task automatic test_multi_pixel();
        bit to;
        logic [7:0] a0h, a0l, a1h, a1l;
        a0h = 8'($urandom_range(0, 3)); a0l = 8'($urandom_range(0, 3));
        a1h = 8'($urandom_range(0, 3)); a1l = 8'($urandom_range(0, 3));
        for (int i = 0; i < 64; i++) mem[i] = ($urandom() & 32'hff00_0000) | 32'(i) | ($urandom() & 32'h00ff_ff00);
        set_regs(a0h, a0l, a1h, a1l, 8'h3f);
        model_frame(a0h, a0l, a1h, a1l, 8'h3f);
        run_frame(to);
        compress();
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL multi_timeout busy still high"); end
        checks++; if (act_runs.size() !== exp_runs.size()) begin errors++; $display("FAIL multi_nruns got %0d want %0d", act_runs.size(), exp_runs.size()); end
        for (int i = 0; i < act_runs.size() && i < exp_runs.size(); i++) begin
            checks++;
            if (act_runs[i] !== exp_runs[i]) begin errors++; $display("FAIL multi_run[%0d] got %0d want %0d", i, act_runs[i], exp_runs[i]); break; end
        end
        checks++; if (q_addr.size() !== 64) begin errors++; $display("FAIL multi_nreads got %0d want 64", q_addr.size()); end
        for (int i = 0; i < q_addr.size() && i < 64; i++) begin
            checks++;
            if (q_addr[i] !== i) begin errors++; $display("FAIL multi_addr[%0d] got %0d want %0d", i, q_addr[i], i); break; end
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL multi_done_count got %0d want 1", done_cnt); end
    endtask

    task automatic test_reg_latch_ignored_start();
        bit to;
        for (int i = 0; i < 2; i++) mem[i] = $urandom();
        set_regs(8'h02, 8'h03, 8'h23, 8'h04, 8'h01);
        model_frame(8'h02, 8'h03, 8'h23, 8'h04, 8'h01);
        fork
            run_frame(to);
            begin
                int n;
                n = 0;
                @(negedge clk_i);
                while (!bit_code_o && n < 5000) begin @(negedge clk_i); n++; end
                start_i = 1'b1;
                reg_t1h_time_i = 8'h05;
                @(negedge clk_i);
                start_i = 1'b0;
                n = 0;
                while (!done_o && n < 60000) begin @(negedge clk_i); n++; end
                start_i = 1'b1;
                @(negedge clk_i);
                start_i = 1'b0;
            end
        join
        compress();
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL latch1_timeout busy still high"); end
        checks++; if (act_runs.size() !== exp_runs.size()) begin errors++; $display("FAIL latch1_nruns got %0d want %0d", act_runs.size(), exp_runs.size()); end
        for (int i = 0; i < act_runs.size() && i < exp_runs.size(); i++) begin
            checks++;
            if (act_runs[i] !== exp_runs[i]) begin errors++; $display("FAIL latch1_run[%0d] got %0d want %0d", i, act_runs[i], exp_runs[i]); break; end
        end
        checks++; if (q_addr.size() !== 2) begin errors++; $display("FAIL ignored_start_nreads got %0d want 2", q_addr.size()); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL ignored_start_done got %0d want 1", done_cnt); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL ignored_start_busy got %b want 0", busy_o); end
        model_frame(8'h02, 8'h03, 8'h05, 8'h04, 8'h01);
        run_frame(to);
        compress();
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL latch2_timeout busy still high"); end
        checks++; if (act_runs.size() !== exp_runs.size()) begin errors++; $display("FAIL latch2_nruns got %0d want %0d", act_runs.size(), exp_runs.size()); end
        for (int i = 0; i < act_runs.size() && i < exp_runs.size(); i++) begin
            checks++;
            if (act_runs[i] !== exp_runs[i]) begin errors++; $display("FAIL latch2_run[%0d] got %0d want %0d", i, act_runs[i], exp_runs[i]); break; end
        end
    endtask

    task automatic test_mid_reset();
        bit to;
        int n;
        for (int i = 0; i < 16; i++) mem[i] = $urandom();
        mem[5] = mem[5] | 32'h0080_0000;
        set_regs(8'($urandom_range(0, 2)), 8'($urandom_range(0, 2)), 8'($urandom_range(0, 2)), 8'($urandom_range(0, 2)), 8'h0f);
        q_addr.delete();
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        n = 0;
        while (!(q_addr.size() >= 6 && bit_code_o) && n < 20000) begin @(negedge clk_i); n++; end
        checks++; if (bit_code_o !== 1'b1) begin errors++; $display("FAIL midreset_reach_pixel5 line %b want 1", bit_code_o); end
        #1 rst_n_i = 1'b0;
        #1;
        checks++; if (bit_code_o !== 1'b0) begin errors++; $display("FAIL midreset_bit_code got %b want 0", bit_code_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", busy_o); end
        checks++; if (ram_rd_en_o !== 1'b0) begin errors++; $display("FAIL midreset_rd_en got %b want 0", ram_rd_en_o); end
        checks++; if (ram_rd_addr_o !== 8'd0) begin errors++; $display("FAIL midreset_addr got %0d want 0", ram_rd_addr_o); end
        @(negedge clk_i);
        rst_n_i = 1'b1;
        for (int i = 0; i < 2; i++) mem[i] = $urandom();
        set_regs(8'h01, 8'h02, 8'h03, 8'h01, 8'h01);
        model_frame(8'h01, 8'h02, 8'h03, 8'h01, 8'h01);
        run_frame(to);
        compress();
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL restart_timeout busy still high"); end
        checks++; if (q_addr.size() !== 2) begin errors++; $display("FAIL restart_nreads got %0d want 2", q_addr.size()); end
        else begin
            checks++; if (q_addr[0] !== 0 || q_addr[1] !== 1) begin errors++; $display("FAIL restart_addrs got %0d,%0d want 0,1", q_addr[0], q_addr[1]); end
        end
        checks++; if (act_runs.size() !== exp_runs.size()) begin errors++; $display("FAIL restart_nruns got %0d want %0d", act_runs.size(), exp_runs.size()); end
        for (int i = 0; i < act_runs.size() && i < exp_runs.size(); i++) begin
            checks++;
            if (act_runs[i] !== exp_runs[i]) begin errors++; $display("FAIL restart_run[%0d] got %0d want %0d", i, act_runs[i], exp_runs[i]); break; end
        end
    endtask

    task automatic test_extremes();
        bit to;
        mem[0] = 32'hff00_0000;
        set_regs(8'hff, 8'hff, 8'hff, 8'hff, 8'h00);
        model_frame(8'hff, 8'hff, 8'hff, 8'hff, 8'h00);
        run_frame(to);
        compress();
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL extreme_timeout busy still high"); end
        checks++; if (act_runs.size() !== exp_runs.size()) begin errors++; $display("FAIL extreme_nruns got %0d want %0d", act_runs.size(), exp_runs.size()); end
        for (int i = 0; i < act_runs.size() && i < exp_runs.size(); i++) begin
            checks++;
            if (act_runs[i] !== exp_runs[i]) begin errors++; $display("FAIL extreme_run[%0d] got %0d want %0d", i, act_runs[i], exp_runs[i]); break; end
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL extreme_done_count got %0d want 1", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_multi_pixel();
        test_reg_latch_ignored_start();
        test_mid_reset();
        test_extremes();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
